mux_rr_nbit_mto1: RTL and testbench

- Registered N-bit, M-input multiplexer: replaces the fixed-select combinational mux where sources hand off data with valid/ready handshakes.
- A round-robin arbiter with an optional fixed-priority mode chooses among requesting channels.
- The winner is captured in a one-entry output register that holds until accepted downstream.
- Used wherever several pipeline producers share one consumer, e.g. a writeback port or memory request port.

---
 rtl/mux_rr_nbit_mto1.sv | 91 +++++++++
 tb/tb_mux_rr_nbit_mto1.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_nbit_mto1.sv
// Registered M-to-1 N-bit mux with valid/ready handshakes.
// Round-robin or fixed-priority grant feeds a one-entry output register.
module mux_rr_nbit_mto1 #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode_fixed,
  input  logic [M-1:0]                  in_valid,
  input  logic [M*N-1:0]                in_data,
  output logic [M-1:0]                  in_ready,
  output logic                          out_valid,
  output logic [N-1:0]                  out_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_sel,
  input  logic                          out_ready
);

  localparam int SW = (M > 1) ? $clog2(M) : 1;
  localparam logic [SW:0]   MW   = (SW+1)'(M);
  localparam logic [SW-1:0] LAST = SW'(M - 1);

  logic [SW-1:0]  r_ptr;
  logic           r_valid;
  logic [N-1:0]   r_data;
  logic [SW-1:0]  r_sel;

  logic [SW-1:0]  w_base;
  logic [2*M-1:0] w_dbl;
  logic [M-1:0]   w_rot;
  logic [SW-1:0]  w_pos;
  logic [SW:0]    w_sum;
  logic [SW-1:0]  w_gnt;
  logic           w_found;
  logic           w_load;
  logic           w_take;
  logic [N-1:0]   w_din;
  logic [SW-1:0]  w_ptr_nxt;

  assign w_base = mode_fixed ? '0 : r_ptr;
  // Rotate requests so the scan start sits at bit 0.
  assign w_dbl  = {in_valid, in_valid} >> w_base;
  assign w_rot  = w_dbl[M-1:0];

  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = M - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pos   = SW'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, w_base} + {1'b0, w_pos};
  assign w_gnt = (w_sum >= MW) ? SW'(w_sum - MW) : SW'(w_sum);

  always_comb begin
    w_din = '0;
    for (int i = 0; i < M; i++) begin
      if (w_gnt == SW'(i)) w_din = in_data[i*N +: N];
    end
  end

  assign w_load    = ~r_valid | out_ready;
  assign w_take    = w_load & w_found & ~rst;
  assign w_ptr_nxt = (w_gnt == LAST) ? '0 : w_gnt + 1'b1;
  assign in_ready  = w_take ? (M'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= w_din;
      r_sel   <= w_gnt;
      if (!mode_fixed) r_ptr <= w_ptr_nxt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_nbit_mto1.sv
// Bench for mux_rr_nbit_mto1 (N=8, M=3): directed plan then random
// traffic against a behavioural model of the handshake mux.
module tb_mux_rr_nbit_mto1;

  localparam int N  = 8;
  localparam int M  = 3;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           mode_fixed;
  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int checks = 0;
  int failures = 0;

  int            m_ptr = 0;
  logic          m_valid = 1'b0;
  logic [N-1:0]  m_data = '0;
  int            m_sel = 0;

  always #5 clk = ~clk;

  mux_rr_nbit_mto1 #(.N(N), .M(M)) dut (
    .clk(clk),
    .rst(rst),
    .mode_fixed(mode_fixed),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_ready(out_ready)
  );

  function automatic int pick(input logic fx, input int p,
                              input logic [M-1:0] v);
    int start;
    int c;
    start = fx ? 0 : p;
    for (int k = 0; k < M; k++) begin
      c = (start + k) % M;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic fx, input logic [M-1:0] v,
                      input logic [M*N-1:0] d, input logic o, input string tag);
    int g;
    logic ld;
    logic [M-1:0] exp_rdy;
    @(negedge clk);
    rst = r; mode_fixed = fx; in_valid = v; in_data = d; out_ready = o;
    #1;
    ld = !m_valid || o;
    g = pick(fx, m_ptr, v);
    exp_rdy = '0;
    if (!r && ld && g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    assert (in_ready === exp_rdy) else begin
      failures++;
      $error("FAIL %s in_ready got=%b exp=%b", tag, in_ready, exp_rdy);
    end
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data = d[g*N +: N];
      m_sel = g;
      if (!fx) m_ptr = (g + 1) % M;
    end else if (o) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (out_valid === m_valid) else begin
      failures++;
      $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, m_valid);
    end
    checks++;
    assert (out_data === m_data) else begin
      failures++;
      $error("FAIL %s out_data got=%h exp=%h", tag, out_data, m_data);
    end
    checks++;
    assert (out_sel === SW'(m_sel)) else begin
      failures++;
      $error("FAIL %s out_sel got=%0d exp=%0d", tag, out_sel, m_sel);
    end
  endtask

  logic [M*N-1:0] abc;
  logic [M*N-1:0] rd;
  int sel_hist[$];

  initial begin
    rst = 1'b1; mode_fixed = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    abc = {8'hC2, 8'hB1, 8'hA0};

    step(1, 0, 3'b111, abc, 1, "reset0");
    step(1, 0, 3'b111, abc, 1, "reset1");

    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3'b111, abc, 1, "rr_wrap");
      sel_hist.push_back(int'(out_sel));
    end
    checks++;
    assert (sel_hist[3] === 0 && sel_hist[4] === 1 && sel_hist[2] === 2)
    else begin
      failures++;
      $error("FAIL rr_seq got=%0d,%0d,%0d exp=2,0,1",
             sel_hist[2], sel_hist[3], sel_hist[4]);
    end

    step(1, 0, 3'b000, abc, 1, "reset_fx");
    for (int i = 0; i < 3; i++) step(0, 1, 3'b110, abc, 1, "fixed");
    step(0, 0, 3'b110, abc, 1, "rr_resume1");
    step(0, 0, 3'b110, abc, 1, "rr_resume2");

    step(0, 0, 3'b000, abc, 1, "empty");
    step(0, 0, 3'b100, {8'h5A, 8'h11, 8'h22}, 1, "bp_load");
    for (int i = 0; i < 4; i++) step(0, 0, 3'b111, abc, 0, "bp_hold");
    step(0, 0, 3'b111, abc, 1, "bp_release");

    step(0, 0, 3'b000, abc, 1, "drain_clr");
    step(0, 0, 3'b010, {8'h00, 8'h33, 8'h00}, 1, "drain_load");
    step(0, 0, 3'b000, abc, 1, "drain1");
    step(0, 0, 3'b000, abc, 1, "drain2");

    step(0, 0, 3'b111, abc, 0, "mid_fill");
    step(1, 0, 3'b111, abc, 0, "mid_rst");
    step(0, 0, 3'b111, abc, 1, "post_rst");

    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom} & {(M*N){1'b1}};
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 3) == 0,
           M'($urandom_range(0, 7)), rd, $urandom_range(0, 3) != 0,
           "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
